lfsr_checker: RTL



---
 rtl/lfsr_pkg.sv | 17 +
 rtl/lfsr_checker_if.sv | 21 ++
 rtl/lfsr_checker_sat_counter.sv | 34 +++
 rtl/lfsr_checker.sv | 138 +++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: width, feedback taps, next-state function and checker state type.
package lfsr_pkg;

    localparam int LFSR_WIDTH = 16;
    // Feedback taps at bits 15, 13, 12 and 10.
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } lfsr_chk_state_t;

    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] v);
        return {v[LFSR_WIDTH-2:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Sample stream in, lock/error status out, for the LFSR sequence checker.
interface lfsr_checker_if;

    logic                              valid_in;
    logic [lfsr_pkg::LFSR_WIDTH-1:0]   value_in;
    logic                              clear;
    logic                              locked;
    logic                              err;
    logic [15:0]                       err_count;

    modport master (
        output valid_in, value_in, clear,
        input  locked, err, err_count
    );

    modport slave (
        input  valid_in, value_in, clear,
        output locked, err, err_count
    );

endinterface

// File: rtl/lfsr_checker_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/lfsr_checker.sv
// Locks onto a 16-bit LFSR stream without knowing the seed, then flags and counts mismatches.
// Define LFSR_CHECKER_RELOCK_EN to drop lock after LOSS_COUNT consecutive mismatches.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    lfsr_checker_if.slave bus
);

    if (LOCK_COUNT < 1 || LOCK_COUNT > 15) begin : g_bad_lock_count
        $error("lfsr_checker: LOCK_COUNT must be in 1..15");
    end
    if (LOSS_COUNT < 1 || LOSS_COUNT > 15) begin : g_bad_loss_count
        $error("lfsr_checker: LOSS_COUNT must be in 1..15");
    end

    localparam logic [3:0] LOCK_LIM = 4'(LOCK_COUNT);

    lfsr_chk_state_t         state_q, state_d;
    logic [LFSR_WIDTH-1:0]   prev_q, prev_d;
    logic                    have_prev_q, have_prev_d;
    logic [3:0]              match_cnt_q, match_cnt_d;
    logic [LFSR_WIDTH-1:0]   expected_q, expected_d;
    logic                    err_q, err_d;
    logic                    mismatch;

`ifdef LFSR_CHECKER_RELOCK_EN
    localparam logic [3:0] LOSS_LIM = 4'(LOSS_COUNT);
    logic [3:0]              miss_cnt_q, miss_cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        match_cnt_d = match_cnt_q;
        expected_d  = expected_q;
        err_d       = 1'b0;
        mismatch    = 1'b0;
`ifdef LFSR_CHECKER_RELOCK_EN
        miss_cnt_d  = miss_cnt_q;
`endif
        if (bus.valid_in) begin
            case (state_q)
                HUNT: begin
                    if (bus.value_in == '0) begin
                        match_cnt_d = '0;
                        have_prev_d = 1'b0;
                    end else begin
                        prev_d      = bus.value_in;
                        have_prev_d = 1'b1;
                        if (have_prev_q && (bus.value_in == lfsr_next(prev_q))) begin
                            match_cnt_d = match_cnt_q + 4'd1;
                            if (match_cnt_q == LOCK_LIM - 4'd1) begin
                                state_d    = LOCKED;
                                expected_d = lfsr_next(bus.value_in);
`ifdef LFSR_CHECKER_RELOCK_EN
                                miss_cnt_d = '0;
`endif
                            end
                        end else begin
                            match_cnt_d = '0;
                        end
                    end
                end
                LOCKED: begin
                    // Prediction free-runs so one corrupted sample costs exactly one error.
                    expected_d = lfsr_next(expected_q);
                    if (bus.value_in != expected_q) begin
                        err_d    = 1'b1;
                        mismatch = 1'b1;
`ifdef LFSR_CHECKER_RELOCK_EN
                        miss_cnt_d = miss_cnt_q + 4'd1;
                        if (miss_cnt_q == LOSS_LIM - 4'd1) begin
                            state_d     = HUNT;
                            match_cnt_d = '0;
                            if (bus.value_in == '0) begin
                                have_prev_d = 1'b0;
                            end else begin
                                prev_d      = bus.value_in;
                                have_prev_d = 1'b1;
                            end
                        end
`endif
                    end
`ifdef LFSR_CHECKER_RELOCK_EN
                    else begin
                        miss_cnt_d = '0;
                    end
`endif
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            match_cnt_q <= '0;
            expected_q  <= '0;
            err_q       <= 1'b0;
`ifdef LFSR_CHECKER_RELOCK_EN
            miss_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
            match_cnt_q <= match_cnt_d;
            expected_q  <= expected_d;
            err_q       <= err_d;
`ifdef LFSR_CHECKER_RELOCK_EN
            miss_cnt_q  <= miss_cnt_d;
`endif
        end
    end

    sat_counter #(
        .WIDTH (16)
    ) u_err_count (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (mismatch),
        .clr   (bus.clear),
        .count (bus.err_count)
    );

    assign bus.locked = (state_q == LOCKED);
    assign bus.err    = err_q;

endmodule
